// File: rtl/vecmac_accum4_pkg.sv
// Shared constants and types for the vecmac_accum4 dot-product accumulator.
// Lane extension is a shared helper so the adder tree and any future lane logic agree.
package vecmac_pkg;

    localparam int LANES     = 4;
    localparam int PROD_W    = 16;
    localparam int SUM4_W    = 18;
    localparam int ACC_W_DEF = 32;

    typedef logic [LANES-1:0][PROD_W-1:0] prod_lanes_t;

    function automatic logic [PROD_W:0] lane_ext(input logic [PROD_W-1:0] p, input bit sgn);
        return {sgn & p[PROD_W-1], p};
    endfunction

endpackage

// File: rtl/vecmac_accum4_if.sv
// Beat input / result output bundle between the multiplier pipeline and vecmac_accum4.
interface vecmac_accum4_if #(parameter int ACC_W = 32);

    logic             in_valid;
    logic             in_last;
    logic [63:0]      product;
    logic             clear;
    logic             out_valid;
    logic [ACC_W-1:0] result;
    logic [15:0]      out_count;
    logic             out_ovf;

    modport master (
        output in_valid, in_last, product, clear,
        input  out_valid, result, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_last, product, clear,
        output out_valid, result, out_count, out_ovf
    );

endinterface

// File: rtl/vecmac_accum4_add_tree4.sv
// Two-register-stage reduction of four 16-bit lanes into an 18-bit sum.
// Valid/last ride alongside the data; clear kills both stages' valids.
module add_tree4 import vecmac_pkg::*; #(
    parameter bit SIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic              in_last,
    input  prod_lanes_t       lanes,
    output logic              out_valid,
    output logic              out_last,
    output logic [SUM4_W-1:0] sum4
);

    logic [PROD_W:0] s01;
    logic [PROD_W:0] s23;
    logic            s1_valid;
    logic            s1_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s01       <= '0;
            s23       <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            sum4      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            s1_valid  <= in_valid & ~clear;
            s1_last   <= in_valid & in_last;
            s01       <= lane_ext(lanes[0], SIGNED) + lane_ext(lanes[1], SIGNED);
            s23       <= lane_ext(lanes[2], SIGNED) + lane_ext(lanes[3], SIGNED);
            out_valid <= s1_valid & ~clear;
            out_last  <= s1_last;
            sum4      <= {SIGNED & s01[PROD_W], s01} + {SIGNED & s23[PROD_W], s23};
        end
    end

endmodule

// File: rtl/vecmac_accum4.sv
// Accumulates reduced 4-lane beats into a running dot product; emits sum, beat
// count and sticky overflow when a beat tagged last reaches the accumulator.
(* use_dsp = "no" *)
module vecmac_accum4 import vecmac_pkg::*; #(
    parameter int ACC_W  = ACC_W_DEF,
    parameter bit SIGNED = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    vecmac_accum4_if.slave  bus
);

    logic              s2_valid;
    logic              s2_last;
    logic [SUM4_W-1:0] sum4;

    logic [ACC_W-1:0]  addend;
    logic [ACC_W-1:0]  base;
    logic [ACC_W:0]    nxt;
    logic              ovf_step;
    logic              ovf_nxt;
    logic [15:0]       cnt_nxt;

    logic [ACC_W-1:0]  acc;
    logic              first;
    logic [15:0]       cnt;
    logic              ovf_sticky;

    logic              out_valid_q;
    logic [ACC_W-1:0]  result_q;
    logic [15:0]       out_count_q;
    logic              out_ovf_q;

    add_tree4 #(.SIGNED(SIGNED)) u_tree (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.clear),
        .in_valid  (bus.in_valid),
        .in_last   (bus.in_last),
        .lanes     (prod_lanes_t'(bus.product)),
        .out_valid (s2_valid),
        .out_last  (s2_last),
        .sum4      (sum4)
    );

    always_comb begin
        if (SIGNED) addend = ACC_W'($signed(sum4));
        else        addend = ACC_W'(sum4);

        base = first ? '0 : acc;
        nxt  = {1'b0, base} + {1'b0, addend};

        // Signed overflow: like-signed operands producing an opposite-signed sum.
        if (SIGNED) ovf_step = (base[ACC_W-1] == addend[ACC_W-1]) && (nxt[ACC_W-1] != base[ACC_W-1]);
        else        ovf_step = nxt[ACC_W];

        ovf_nxt = ovf_step | (ovf_sticky & ~first);

        if (first)           cnt_nxt = 16'd1;
        else if (cnt == '1)  cnt_nxt = cnt;
        else                 cnt_nxt = cnt + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            first       <= 1'b1;
            cnt         <= '0;
            ovf_sticky  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (bus.clear) begin
                first <= 1'b1;
            end else if (s2_valid) begin
                acc        <= nxt[ACC_W-1:0];
                cnt        <= cnt_nxt;
                ovf_sticky <= ovf_nxt;
                first      <= s2_last;
                if (s2_last) begin
                    result_q    <= nxt[ACC_W-1:0];
                    out_count_q <= cnt_nxt;
                    out_ovf_q   <= ovf_nxt;
                    out_valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_vecmac_accum4.sv
// Scoreboard bench: three DUT configurations share one stimulus stream and are
// checked against an arithmetic model of the dot-product rules.
module tb_vecmac_accum4;

    typedef struct {
        logic [63:0] res;
        logic [63:0] cnt;
        logic [63:0] ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [63:0] product = '0;
    logic        clear = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int W [3]  = '{32, 32, 18};
    bit SG [3] = '{1'b1, 1'b0, 1'b1};

    exp_t   exp_q [3][$];
    longint macc [3];
    int     mn   [3];
    bit     mov  [3];

    int          npulse   [3];
    logic [63:0] last_res [3];
    logic [63:0] last_cnt [3];
    logic [63:0] last_ovf [3];
    logic [63:0] prev_res [3];
    int          last_cyc [3];
    int          prev_cyc [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vecmac_accum4_if #(.ACC_W(32)) b0 ();
    vecmac_accum4_if #(.ACC_W(32)) b1 ();
    vecmac_accum4_if #(.ACC_W(18)) b2 ();

    assign b0.in_valid = in_valid;  assign b0.in_last = in_last;
    assign b0.product  = product;   assign b0.clear   = clear;
    assign b1.in_valid = in_valid;  assign b1.in_last = in_last;
    assign b1.product  = product;   assign b1.clear   = clear;
    assign b2.in_valid = in_valid;  assign b2.in_last = in_last;
    assign b2.product  = product;   assign b2.clear   = clear;

    vecmac_accum4 #(.ACC_W(32), .SIGNED(1'b1)) u_s32 (.clk(clk), .rst(rst), .bus(b0.slave));
    vecmac_accum4 #(.ACC_W(32), .SIGNED(1'b0)) u_u32 (.clk(clk), .rst(rst), .bus(b1.slave));
    vecmac_accum4 #(.ACC_W(18), .SIGNED(1'b1)) u_s18 (.clk(clk), .rst(rst), .bus(b2.slave));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Reference model: true integer sums, range-checked and wrapped per step.
    function automatic longint beat_sum(input int k, input logic [63:0] p);
        longint s = 0;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] l;
            l = p[16*i +: 16];
            s += SG[k] ? longint'($signed(l)) : longint'(l);
        end
        return s;
    endfunction

    task automatic model_reset(input int k);
        macc[k] = 0;
        mn[k]   = 0;
        mov[k]  = 1'b0;
    endtask

    task automatic model_beat(input int k, input logic [63:0] p, input bit last);
        longint m, lo, hi, t, u;
        exp_t e;
        m  = longint'(1) << W[k];
        lo = SG[k] ? -(m / 2) : 0;
        hi = SG[k] ? (m / 2 - 1) : (m - 1);
        t  = macc[k] + beat_sum(k, p);
        if (t < lo || t > hi) mov[k] = 1'b1;
        u = ((t % m) + m) % m;
        if (SG[k] && u >= m / 2) u -= m;
        macc[k] = u;
        mn[k]++;
        if (last) begin
            e.res = 64'(((macc[k] % m) + m) % m);
            e.cnt = 64'((mn[k] > 65535) ? 65535 : mn[k]);
            e.ovf = 64'(mov[k]);
            exp_q[k].push_back(e);
            model_reset(k);
        end
    endtask

    task automatic drive(input bit v, input bit l, input logic [63:0] p, input bit c);
        @(posedge clk);
        #1;
        in_valid = v;
        in_last  = l;
        product  = p;
        clear    = c;
        for (int k = 0; k < 3; k++) begin
            if (c)      model_reset(k);
            else if (v) model_beat(k, p, l);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic check_zero_outputs();
        chk("rst_valid0", 64'(b0.out_valid), 0);  chk("rst_res0", 64'(b0.result), 0);
        chk("rst_cnt0",   64'(b0.out_count), 0);  chk("rst_ovf0", 64'(b0.out_ovf), 0);
        chk("rst_valid1", 64'(b1.out_valid), 0);  chk("rst_res1", 64'(b1.result), 0);
        chk("rst_cnt1",   64'(b1.out_count), 0);  chk("rst_ovf1", 64'(b1.out_ovf), 0);
        chk("rst_valid2", 64'(b2.out_valid), 0);  chk("rst_res2", 64'(b2.result), 0);
        chk("rst_cnt2",   64'(b2.out_count), 0);  chk("rst_ovf2", 64'(b2.out_ovf), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0; in_last = 1'b0; product = '0; clear = 1'b0;
        for (int k = 0; k < 3; k++) begin
            model_reset(k);
            exp_q[k].delete();
        end
        @(negedge clk);
        check_zero_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic mon_one(input int k, input bit v, input logic [63:0] res,
                           input logic [63:0] cnt, input logic [63:0] ovf);
        exp_t e;
        if (!v) return;
        npulse[k]++;
        prev_res[k] = last_res[k];
        prev_cyc[k] = last_cyc[k];
        last_res[k] = res;
        last_cnt[k] = cnt;
        last_ovf[k] = ovf;
        last_cyc[k] = cyc;
        if (exp_q[k].size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_out_valid[%0d]: got pulse, required none (result 0x%0h)", k, res);
            return;
        end
        e = exp_q[k].pop_front();
        chk($sformatf("result[%0d]", k), res, e.res);
        chk($sformatf("out_count[%0d]", k), cnt, e.cnt);
        chk($sformatf("out_ovf[%0d]", k), ovf, e.ovf);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon_one(0, b0.out_valid, 64'(b0.result), 64'(b0.out_count), 64'(b0.out_ovf));
            mon_one(1, b1.out_valid, 64'(b1.result), 64'(b1.out_count), 64'(b1.out_ovf));
            mon_one(2, b2.out_valid, 64'(b2.result), 64'(b2.out_count), 64'(b2.out_ovf));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int since_valid;
        for (int k = 0; k < 3; k++) begin
            model_reset(k);
            npulse[k] = 0; last_res[k] = '0; prev_res[k] = '0;
            last_cnt[k] = '0; last_ovf[k] = '0; last_cyc[k] = 0; prev_cyc[k] = 0;
        end

        do_reset();

        // Single unsigned beat of 0x3F01 lanes.
        drive(1'b1, 1'b1, {4{16'h3F01}}, 1'b0);
        idle(5);
        chk("single_u_result", last_res[1], 64'h0000FC04);
        chk("single_u_count",  last_cnt[1], 64'd1);
        chk("single_u_ovf",    last_ovf[1], 64'd0);

        // Signed negative lanes, two beats.
        drive(1'b1, 1'b0, {4{16'hC080}}, 1'b0);
        drive(1'b1, 1'b1, {4{16'hC080}}, 1'b0);
        idle(5);
        chk("neg_s_result", last_res[0], 64'hFFFE0400);
        chk("neg_s_count",  last_cnt[0], 64'd2);

        // Three beats overflow an 18-bit signed accumulator.
        repeat (2) drive(1'b1, 1'b0, {4{16'h3F01}}, 1'b0);
        drive(1'b1, 1'b1, {4{16'h3F01}}, 1'b0);
        idle(5);
        chk("ovf18_result", last_res[2], 64'h2F40C);
        chk("ovf18_ovf",    last_ovf[2], 64'd1);
        chk("ovf18_count",  last_cnt[2], 64'd3);

        // Back-to-back single-beat vectors.
        drive(1'b1, 1'b1, {4{16'd1}}, 1'b0);
        drive(1'b1, 1'b1, {4{16'd2}}, 1'b0);
        idle(5);
        chk("b2b_first",  prev_res[0], 64'd4);
        chk("b2b_second", last_res[0], 64'd8);
        chk("b2b_adjacent", 64'(last_cyc[0] - prev_cyc[0]), 64'd1);

        // Gap inside a vector.
        drive(1'b1, 1'b0, {4{16'd5}}, 1'b0);
        idle(3);
        drive(1'b1, 1'b1, {4{16'd7}}, 1'b0);
        idle(5);
        chk("gap_result", last_res[0], 64'd48);
        chk("gap_count",  last_cnt[0], 64'd2);

        // Mid-vector clear with a concurrent beat, then a fresh vector.
        p0 = npulse[0];
        drive(1'b1, 1'b0, {4{16'd9}}, 1'b0);
        idle(2);
        drive(1'b1, 1'b0, {4{16'd100}}, 1'b1);
        drive(1'b1, 1'b1, {4{16'd3}}, 1'b0);
        idle(5);
        chk("clear_pulses", 64'(npulse[0] - p0), 64'd1);
        chk("clear_result", last_res[0], 64'd12);
        chk("clear_count",  last_cnt[0], 64'd1);

        // Reset one cycle after a last beat: in-flight vector vanishes.
        p0 = npulse[0];
        drive(1'b1, 1'b1, {4{16'd4}}, 1'b0);
        do_reset();
        idle(5);
        chk("rst_flight_pulses", 64'(npulse[0] - p0), 64'd0);
        drive(1'b1, 1'b1, {4{16'd6}}, 1'b0);
        idle(5);
        chk("post_rst_result", last_res[0], 64'd24);

        // Randomized traffic; clear only once the pipeline holds no beats.
        since_valid = 0;
        for (int i = 0; i < 400; i++) begin
            bit v, l, c;
            logic [63:0] p;
            p = {$urandom(), $urandom()};
            c = (since_valid >= 2) && ($urandom_range(0, 19) == 0);
            v = ($urandom_range(0, 9) < 7);
            l = ($urandom_range(0, 3) == 0);
            drive(v, l, p, c);
            since_valid = v ? 0 : since_valid + 1;
        end
        idle(8);

        chk("drain_q0", 64'(exp_q[0].size()), 64'd0);
        chk("drain_q1", 64'(exp_q[1].size()), 64'd0);
        chk("drain_q2", 64'(exp_q[2].size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
